// File: rtl/bus_frame_receiver.sv
// -----------------------------------------------------------------------------
// bus_frame_receiver
//
// Receive-side endpoint of the shared one-bit node bus. Watches the bus for a
// start bit and then deserialises one 77-bit frame, one bit per clock, MSB
// first:
//
//    start(1) | DST[3:0] | SRC[3:0] | DATA[63:0] | CRC[3:0]
//
// A CRC-4 (x^4 + x + 1) is recomputed over the 64 DATA bits and compared with
// the received CRC field on the last frame bit. Frames addressed to this node
// or to the broadcast address produce either a data_valid strobe (CRC good)
// or a crc_err strobe (CRC bad). Frames for other nodes are consumed silently
// so the receiver stays aligned to the frame stream.
//
// Ports
//    clock       in   1   system clock, all logic on the rising edge
//    reset       in   1   synchronous, active-high reset
//    bus_in      in   1   serial bus line, idle level 0
//    data_out    out  64  payload of the last accepted frame (held)
//    src_addr    out  4   source ID of the last accepted frame (held)
//    data_valid  out  1   one-cycle pulse: addressed frame, CRC good
//    crc_err     out  1   one-cycle pulse: addressed frame, CRC mismatch
//    busy        out  1   high while a frame is in progress (state != IDLE)
//    rx_count    out  8   accepted-frame counter, saturates at 255
//    err_count   out  8   CRC-error counter, saturates at 255
//
// Parameters
//    NODE_ADDR   this node's bus address; must differ from BCAST_ADDR
//    BCAST_ADDR  broadcast address accepted by every node
// -----------------------------------------------------------------------------
module bus_frame_receiver #(
   parameter logic [3:0] NODE_ADDR  = 4'd1,
   parameter logic [3:0] BCAST_ADDR = 4'hF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        bus_in,
   output logic [63:0] data_out,
   output logic [3:0]  src_addr,
   output logic        data_valid,
   output logic        crc_err,
   output logic        busy,
   output logic [7:0]  rx_count,
   output logic [7:0]  err_count
);

   // Field lengths, expressed as the last value of the per-field bit counter.
   localparam logic [6:0] ADDR_LAST = 7'd3;    // DST, SRC and CRC are 4 bits
   localparam logic [6:0] DATA_LAST = 7'd63;   // DATA is 64 bits

   // CRC-4 generator x^4 + x + 1, without the implicit x^4 term.
   localparam logic [3:0] CRC_POLY = 4'b0011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DST,
      S_SRC,
      S_DATA,
      S_CRC
   } state_t;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t      r_state;
   logic [6:0]  r_bit_cnt;     // bit index within the current field
   logic [3:0]  r_dst;         // destination address shift register
   logic [3:0]  r_src;         // source ID shift register
   logic [63:0] r_data;        // payload shift register
   logic [3:0]  r_crc_calc;    // running CRC over the DATA bits
   logic [2:0]  r_crc_rx;      // first three received CRC bits
   logic [63:0] r_data_out;
   logic [3:0]  r_src_addr;
   logic        r_data_valid;
   logic        r_crc_err;
   logic [7:0]  r_rx_count;
   logic [7:0]  r_err_count;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   state_t      w_next_state;
   logic        w_field_last;  // current bit is the last bit of its field
   logic        w_frame_done;  // current bit is the last bit of the frame
   logic        w_addr_match;
   logic [3:0]  w_crc_rx;      // complete received CRC, including this bit
   logic        w_crc_fb;
   logic [3:0]  w_crc_next;
   logic        w_crc_good;
   logic        w_accept;
   logic        w_reject;

   // The field-end test depends on which field is being received; DATA is the
   // only long field, the other three are all four bits wide.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can
      // leave it unassigned, which would otherwise infer a latch.
      w_field_last = 1'b0;
      unique case (r_state)
         S_DST, S_SRC, S_CRC: w_field_last = (r_bit_cnt == ADDR_LAST);
         S_DATA:              w_field_last = (r_bit_cnt == DATA_LAST);
         default:             w_field_last = 1'b0;
      endcase
   end

   assign w_frame_done = (r_state == S_CRC) && w_field_last;

   // DST is complete long before the decision point, so the match is stable
   // for the whole CRC field.
   assign w_addr_match = (r_dst == NODE_ADDR) || (r_dst == BCAST_ADDR);

   // The last CRC bit is still on the bus when the decision is made, so it is
   // appended to the three bits already captured.
   assign w_crc_rx   = {r_crc_rx, bus_in};

   assign w_crc_fb   = bus_in ^ r_crc_calc[3];
   assign w_crc_next = {r_crc_calc[2:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 4'b0000);

   assign w_crc_good = (w_crc_rx == r_crc_calc);
   assign w_accept   = w_frame_done && w_addr_match &&  w_crc_good;
   assign w_reject   = w_frame_done && w_addr_match && !w_crc_good;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement
      // order across always_ff blocks.
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         // Any 1 seen while idle is a start bit; there is no glitch filter.
         S_IDLE: if (bus_in)       w_next_state = S_DST;
         S_DST:  if (w_field_last) w_next_state = S_SRC;
         S_SRC:  if (w_field_last) w_next_state = S_DATA;
         S_DATA: if (w_field_last) w_next_state = S_CRC;
         S_CRC:  if (w_field_last) w_next_state = S_IDLE;
         default:                  w_next_state = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Bit counter and field shift registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: the shift registers are reset along with the control state even
      // though a new frame overwrites them; this keeps an aborted frame from
      // leaking into simulation traces and costs nothing on these few flops.
      if (reset) begin
         r_bit_cnt  <= '0;
         r_dst      <= '0;
         r_src      <= '0;
         r_data     <= '0;
         r_crc_calc <= '0;
         r_crc_rx   <= '0;
      end else begin
         // Counter restarts at every field boundary and holds at 0 while idle.
         if (r_state == S_IDLE || w_field_last) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + 7'd1;
         end

         unique case (r_state)
            S_IDLE: begin
               // The CRC seed is applied on the start bit so the first DATA
               // bit always sees a clean register.
               if (bus_in) r_crc_calc <= '0;
            end
            S_DST:  r_dst    <= {r_dst[2:0], bus_in};
            S_SRC:  r_src    <= {r_src[2:0], bus_in};
            S_DATA: begin
               r_data     <= {r_data[62:0], bus_in};
               r_crc_calc <= w_crc_next;
            end
            S_CRC:  r_crc_rx <= {r_crc_rx[1:0], bus_in};
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Result registers, strobes and saturating counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_data_out   <= '0;
         r_src_addr   <= '0;
         r_data_valid <= 1'b0;
         r_crc_err    <= 1'b0;
         r_rx_count   <= '0;
         r_err_count  <= '0;
      end else begin
         // Strobes are one cycle wide; w_accept and w_reject are mutually
         // exclusive by construction, so the two never overlap.
         r_data_valid <= w_accept;
         r_crc_err    <= w_reject;

         if (w_accept) begin
            r_data_out <= r_data;
            r_src_addr <= r_src;
            if (r_rx_count != 8'hFF) r_rx_count <= r_rx_count + 8'd1;
         end

         if (w_reject && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign data_out   = r_data_out;
   assign src_addr   = r_src_addr;
   assign data_valid = r_data_valid;
   assign crc_err    = r_crc_err;
   assign busy       = (r_state != S_IDLE);
   assign rx_count   = r_rx_count;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_bus_frame_receiver
//
// Directed testbench for bus_frame_receiver with NODE_ADDR = 1. Frames are
// driven on the falling edge; a falling-edge monitor records strobe cycles
// (relative to a rising-edge counter) and busy cycles. Expected CRCs are the
// hand-computed values for payloads 1, 2 and 3 (4'h3, 4'h6, 4'h5).
// -----------------------------------------------------------------------------
module tb_bus_frame_receiver;

   logic        clock;
   logic        reset;
   logic        bus_in;
   logic [63:0] data_out;
   logic [3:0]  src_addr;
   logic        data_valid;
   logic        crc_err;
   logic        busy;
   logic [7:0]  rx_count;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   int cyc = 0;          // number of rising edges so far
   int busy_cnt = 0;     // falling edges with busy observed high
   int both_high = 0;    // falling edges with both strobes high
   int valid_q[$];       // cycle stamps of data_valid pulses
   int err_q[$];         // cycle stamps of crc_err pulses

   bus_frame_receiver #(
      .NODE_ADDR (4'd1),
      .BCAST_ADDR(4'hF)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus_in    (bus_in),
      .data_out  (data_out),
      .src_addr  (src_addr),
      .data_valid(data_valid),
      .crc_err   (crc_err),
      .busy      (busy),
      .rx_count  (rx_count),
      .err_count (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (data_valid) valid_q.push_back(cyc);
      if (crc_err)    err_q.push_back(cyc);
      if (busy)       busy_cnt = busy_cnt + 1;
      if (data_valid && crc_err) both_high = both_high + 1;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus_in = 1'b0;
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset  = 1'b1;
      bus_in = 1'b0;
      @(negedge clock);
      reset  = 1'b0;
      #1;
   endtask

   // Drives one frame, bit p sampled at edge Ep. If abort_at >= 0, reset is
   // held high (with the bus forced high) for the cycle containing E<abort_at>
   // and the frame is abandoned. e0 returns the rising-edge count at E0.
   task automatic send_frame(input logic [3:0] dst, input logic [3:0] src,
                             input logic [63:0] data, input logic [3:0] crc,
                             input int abort_at, output int e0);
      logic [76:0] f;
      f = {1'b1, dst, src, data, crc};
      e0 = 0;
      for (int p = 0; p < 77; p++) begin
         @(negedge clock);
         if (p == 0) e0 = cyc + 1;
         if (p == abort_at) begin
            reset  = 1'b1;
            bus_in = 1'b1;
            @(negedge clock);
            reset  = 1'b0;
            bus_in = 1'b0;
            break;
         end
         bus_in = f[76-p];
      end
   endtask

   task automatic clear_monitor();
      valid_q.delete();
      err_q.delete();
      busy_cnt  = 0;
      both_high = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (data_out !== 64'h0) begin
         $display("FAIL reset_data_out: got %h expected %h", data_out, 64'h0);
         errors++;
      end
      checks++;
      if (src_addr !== 4'h0) begin
         $display("FAIL reset_src_addr: got %h expected %h", src_addr, 4'h0);
         errors++;
      end
      checks++;
      if ({busy, data_valid, crc_err} !== 3'b000) begin
         $display("FAIL reset_flags: got busy/valid/err %b expected 000",
                  {busy, data_valid, crc_err});
         errors++;
      end
      checks++;
      if ({rx_count, err_count} !== 16'h0) begin
         $display("FAIL reset_counts: got rx %0d err %0d expected 0 0",
                  rx_count, err_count);
         errors++;
      end
   endtask

   task automatic test_good_frame();
      int e0;
      apply_reset();
      clear_monitor();
      send_frame(4'd1, 4'd2, 64'h1, 4'h3, -1, e0);
      idle(2);
      checks++;
      if (valid_q.size() != 1 || valid_q[0] != e0 + 76) begin
         $display("FAIL good_valid_pulse: got %0d pulses first at %0d expected 1 at %0d",
                  valid_q.size(), (valid_q.size() > 0) ? valid_q[0] : -1, e0 + 76);
         errors++;
      end
      checks++;
      if (data_out !== 64'h1 || src_addr !== 4'd2) begin
         $display("FAIL good_payload: got data %h src %h expected %h %h",
                  data_out, src_addr, 64'h1, 4'd2);
         errors++;
      end
      checks++;
      if (rx_count !== 8'd1 || err_q.size() != 0) begin
         $display("FAIL good_counts: got rx %0d crc_err pulses %0d expected 1 0",
                  rx_count, err_q.size());
         errors++;
      end
   endtask

   task automatic test_crc_error();
      int e0;
      apply_reset();
      clear_monitor();
      send_frame(4'd1, 4'd2, 64'h1, 4'h1, -1, e0);
      idle(2);
      checks++;
      if (err_q.size() != 1 || err_q[0] != e0 + 76) begin
         $display("FAIL crc_err_pulse: got %0d pulses first at %0d expected 1 at %0d",
                  err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, e0 + 76);
         errors++;
      end
      checks++;
      if (err_count !== 8'd1 || rx_count !== 8'd0) begin
         $display("FAIL crc_err_counts: got err %0d rx %0d expected 1 0",
                  err_count, rx_count);
         errors++;
      end
      checks++;
      if (data_out !== 64'h0 || src_addr !== 4'h0 || valid_q.size() != 0) begin
         $display("FAIL crc_err_hold: got data %h src %h valid pulses %0d expected 0 0 0",
                  data_out, src_addr, valid_q.size());
         errors++;
      end
   endtask

   task automatic test_addressing();
      int e0;
      logic [7:0] rx0, err0;
      logic [63:0] d0;
      rx0 = rx_count;
      err0 = err_count;
      d0 = data_out;
      clear_monitor();
      send_frame(4'd5, 4'd2, 64'h2, 4'h6, -1, e0);
      idle(2);
      checks++;
      if (valid_q.size() != 0 || err_q.size() != 0) begin
         $display("FAIL other_addr_pulses: got valid %0d err %0d expected 0 0",
                  valid_q.size(), err_q.size());
         errors++;
      end
      checks++;
      if (rx_count !== rx0 || err_count !== err0 || data_out !== d0) begin
         $display("FAIL other_addr_state: got rx %0d err %0d data %h expected %0d %0d %h",
                  rx_count, err_count, data_out, rx0, err0, d0);
         errors++;
      end
      checks++;
      if (busy_cnt != 76) begin
         $display("FAIL other_addr_busy: got %0d busy cycles expected 76", busy_cnt);
         errors++;
      end
      clear_monitor();
      send_frame(4'hF, 4'd7, 64'h3, 4'h5, -1, e0);
      idle(2);
      checks++;
      if (valid_q.size() != 1 || data_out !== 64'h3 || src_addr !== 4'd7) begin
         $display("FAIL bcast_accept: got pulses %0d data %h src %h expected 1 %h %h",
                  valid_q.size(), data_out, src_addr, 64'h3, 4'd7);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int e0, e1;
      apply_reset();
      clear_monitor();
      send_frame(4'd1, 4'd3, 64'h2, 4'h6, -1, e0);
      send_frame(4'd1, 4'd4, 64'h3, 4'h5, -1, e1);
      idle(2);
      checks++;
      if (valid_q.size() != 2 || valid_q[0] != e0 + 76 || valid_q[1] != e0 + 153) begin
         $display("FAIL b2b_pulses: got %0d pulses at %0d,%0d expected 2 at %0d,%0d",
                  valid_q.size(), (valid_q.size() > 0) ? valid_q[0] : -1,
                  (valid_q.size() > 1) ? valid_q[1] : -1, e0 + 76, e0 + 153);
         errors++;
      end
      checks++;
      if (rx_count !== 8'd2 || data_out !== 64'h3 || src_addr !== 4'd4) begin
         $display("FAIL b2b_result: got rx %0d data %h src %h expected 2 %h %h",
                  rx_count, data_out, src_addr, 64'h3, 4'd4);
         errors++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      clear_monitor();
      // rx_count is non-zero here, so a missing counter reset is visible.
      send_frame(4'd1, 4'd2, 64'h1, 4'h3, 40, e0);
      idle(3);
      checks++;
      if (valid_q.size() != 0 || err_q.size() != 0 || busy !== 1'b0) begin
         $display("FAIL abort_quiet: got valid %0d err %0d busy %b expected 0 0 0",
                  valid_q.size(), err_q.size(), busy);
         errors++;
      end
      checks++;
      if (rx_count !== 8'd0 || data_out !== 64'h0) begin
         $display("FAIL abort_cleared: got rx %0d data %h expected 0 %h",
                  rx_count, data_out, 64'h0);
         errors++;
      end
      send_frame(4'd1, 4'd2, 64'h1, 4'h3, -1, e0);
      idle(2);
      checks++;
      if (rx_count !== 8'd1 || valid_q.size() != 1 || data_out !== 64'h1) begin
         $display("FAIL abort_recover: got rx %0d pulses %0d data %h expected 1 1 %h",
                  rx_count, valid_q.size(), data_out, 64'h1);
         errors++;
      end
   endtask

   task automatic test_saturation();
      int e0;
      apply_reset();
      clear_monitor();
      for (int i = 1; i <= 257; i++) begin
         send_frame(4'd1, 4'd2, 64'h1, 4'h3, -1, e0);
         idle(1);
         if (i == 254) begin
            checks++;
            if (rx_count !== 8'd254) begin
               $display("FAIL sat_254: got %0d expected 254", rx_count);
               errors++;
            end
         end
      end
      idle(2);
      checks++;
      if (rx_count !== 8'd255) begin
         $display("FAIL sat_count: got %0d expected 255", rx_count);
         errors++;
      end
      checks++;
      if (valid_q.size() != 257) begin
         $display("FAIL sat_pulses: got %0d expected 257", valid_q.size());
         errors++;
      end
      checks++;
      if (both_high != 0 || err_count !== 8'd0) begin
         $display("FAIL sat_no_err: got overlap %0d err %0d expected 0 0",
                  both_high, err_count);
         errors++;
      end
   endtask

   initial begin
      reset  = 1'b1;
      bus_in = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      test_reset();
      test_good_frame();
      test_crc_error();
      test_addressing();
      test_back_to_back();
      test_reset_mid_frame();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_frame_receiver.md
# bus_frame_receiver

Receive-side endpoint of the shared serial node bus driven by the FPGA top. Each instance monitors the one-bit bus, deserialises one frame per transmission (destination address, source ID, 64-bit payload, 4-bit CRC) and recomputes the CRC. Frames addressed to this node or to broadcast are presented on a one-cycle valid strobe. The block keeps saturating counters of accepted and corrupted frames.

## Interface
Parameters:
- NODE_ADDR, 4'd1, this node's 4-bit bus address; must not be 4'hF.
- BCAST_ADDR, 4'hF, broadcast address accepted by every node.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  1  serial bus line, MSB-first frames, idle level 0.
- data_out  out  64  payload of the last accepted frame; holds until the next accepted frame.
- src_addr  out  4  source ID of the last accepted frame.
- data_valid  out  1  one-cycle pulse: accepted frame, CRC good.
- crc_err  out  1  one-cycle pulse: addressed frame with CRC mismatch.
- busy  out  1  high while a frame is being received (state ≠ IDLE).
- rx_count  out  8  accepted-frame counter, saturates at 255.
- err_count  out  8  CRC-error counter, saturates at 255.

## Operation
- Frame is 77 bits, one bit per clock:
  - start bit (1)
  - DST[3:0]
  - SRC[3:0]
  - DATA[63:0]
  - CRC[3:0]
  - All fields MSB first.
- FSM states and transitions:
  - IDLE: bus_in = 1 → DST; otherwise stay.
  - DST: 4 bits → SRC.
  - SRC: 4 bits → DATA.
  - DATA: 64 bits → CRC.
  - CRC: 4 bits → IDLE.
- A 7-bit bit counter drives the field transitions and is cleared when entering each field.
- CRC-4 (x^4+x+1):
  - Runs over the 64 DATA bits only, initialised to 0 at the start bit.
  - Per bit: fb = bit ^ c[3]; c = {c[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - The received CRC field is compared with the final c.
- Address match: DST == NODE_ADDR or DST == BCAST_ADDR.
- Non-matching frames:
  - Still fully consumed, so the receiver stays frame-aligned.
  - No output pulses, no counter change, data_out unchanged.
- On the last CRC bit of a matching frame:
  - CRC good: load data_out/src_addr, pulse data_valid, increment rx_count (saturating).
  - CRC bad: pulse crc_err, increment err_count (saturating), leave data_out/src_addr unchanged.
- data_valid and crc_err are never high in the same cycle.

## Timing
- Reset values:
  - state IDLE, busy 0, data_valid 0, crc_err 0.
  - data_out 64'h0, src_addr 4'h0, rx_count 0, err_count 0.
- Edge numbering: the edge that samples the start bit is E0.
  - DST sampled E1–E4.
  - SRC sampled E5–E8.
  - DATA sampled E9–E72.
  - CRC sampled E73–E76.
- Outputs update at E76:
  - data_valid/crc_err are high between E76 and E77.
  - busy is high from after E0 until E76; it is low after E76.
- Back-to-back frames: a start bit sampled at E77 begins the next frame with zero gap and is fully supported.
- Reset asserted mid-frame:
  - Next edge forces IDLE and discards the partial frame.
  - Outputs and counters go to their reset values.
  - Bus activity during reset is ignored.
  - The first start bit sampled after reset deasserts begins a frame.
- bus_in = 1 in IDLE is always a start bit; there is no glitch filtering.
- Counter saturation: at 255, further events still pulse the strobe but leave the count at 255.

## Test plan
- NODE_ADDR=1; frame DST=1, SRC=2, DATA=64'h1, CRC=4'h3 → data_valid pulse at E76, data_out=64'h1, src_addr=2, rx_count=1, crc_err stays 0.
- Same frame with CRC=4'h1 → crc_err pulse at E76, err_count=1, data_out stays 64'h0, data_valid stays 0.
- Frame DST=5, DATA=64'h2, CRC=4'h6 → no pulses, counters unchanged, busy high for 76 cycles. Then DST=4'hF, DATA=64'h3, CRC=4'h5 → data_valid, data_out=64'h3.
- Two matching frames back to back with zero idle gap (DATA=64'h2/CRC=6, then DATA=64'h3/CRC=5) → pulses at E76 and E153, rx_count=2, final data_out=64'h3.
- Reset asserted for one cycle at E40 of a matching frame, then a clean frame DATA=64'h1, CRC=3 → no pulse for the aborted frame, rx_count=1 after the clean frame.
- 257 good matching frames → rx_count saturates at 255, data_valid pulses on all 257 frames.
